// File: rtl/axi4_lite_regbank.sv
// axi4_lite_regbank
// AXI4-Lite slave exposing NUM_REGS 32-bit registers to user logic.
// Each register is either read/write (stored here, driven on ctrl_regs)
// or read-only (reads come straight from the matching status_in slice).
// Out-of-range and read-only writes are answered with SLVERR and change
// nothing. AW and W are captured into independent one-entry holding
// slots, so the master may present them in any order.
module axi4_lite_regbank #(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = 8'hF0
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    output logic [1:0]              S_AXI_BRESP,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [1:0]              S_AXI_RRESP,
    output logic [32*NUM_REGS-1:0]  ctrl_regs,
    input  logic [32*NUM_REGS-1:0]  status_in,
    output logic [NUM_REGS-1:0]     wr_pulse
);

    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                           out_of_reset;

    logic                           aw_full;
    logic [IDX_W-1:0]               aw_idx;
    logic                           w_full;
    logic [31:0]                    w_data;
    logic [3:0]                     w_strb;
    logic                           commit;
    logic                           wr_ok;

    logic                           ar_busy;
    logic [IDX_W-1:0]               ar_idx;
    logic                           rd_hit;
    logic [31:0]                    rd_val;

    logic [NUM_REGS-1:0][31:0]      regs;

    logic                           aw_hs;
    logic                           w_hs;
    logic                           ar_hs;

    // Byte-address low bits are ignored, and RO slots of the storage array
    // and RW slices of status_in are never consumed; folding them here keeps
    // that explicit rather than leaving dangling bits.
    logic                           unused_bits;
    assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], status_in, regs};

    assign S_AXI_AWREADY = !aw_full && !S_AXI_BVALID && out_of_reset;
    assign S_AXI_WREADY  = !w_full  && !S_AXI_BVALID && out_of_reset;
    assign S_AXI_ARREADY = !S_AXI_RVALID && !ar_busy && out_of_reset;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = aw_full && w_full;

    // Hold off all READYs until the first clock edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    // Capture AW and W into their holding slots; both empty on commit.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
        end
    end

    // A held write may only land on an in-range read/write register.
    always_comb begin
        wr_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(aw_idx) == i && !RO_MASK[i]) begin
                wr_ok = 1'b1;
            end
        end
    end

    // Commit the held write byte-by-byte and strobe the target register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs     <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit && wr_ok) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (int'(aw_idx) == i) begin
                        wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (w_strb[b]) begin
                                regs[i][8*b +: 8] <= w_data[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Raise the write response on commit and hold it until BREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    // Select the read source: stored value for RW, live status for RO.
    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(ar_idx) == i) begin
                rd_hit = 1'b1;
                rd_val = RO_MASK[i] ? status_in[32*i +: 32] : regs[i];
            end
        end
    end

    // Latch the read address, then register data/response one edge later.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ar_busy      <= 1'b0;
            ar_idx       <= '0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else begin
            if (ar_busy) begin
                ar_busy      <= 1'b0;
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_val;
                S_AXI_RRESP  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
            if (ar_hs) begin
                ar_busy <= 1'b1;
                ar_idx  <= S_AXI_ARADDR[ADDR_WIDTH-1:2];
            end
        end
    end

    // Present RW contents to user logic; RO slices read as zero.
    always_comb begin
        ctrl_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!RO_MASK[i]) begin
                ctrl_regs[32*i +: 32] = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// tb_axi4_lite_regbank
// Drives directed and randomised AXI4-Lite traffic into axi4_lite_regbank
// and compares responses, register contents and write strobes against a
// simple array model of the register map.
module tb_axi4_lite_regbank;

    localparam int                  ADDR_WIDTH = 8;
    localparam int                  NUM_REGS   = 8;
    localparam logic [NUM_REGS-1:0] RO_MASK    = 8'hF0;
    localparam logic [1:0]          OKAY       = 2'b00;
    localparam logic [1:0]          SLVERR     = 2'b10;

    logic                    S_AXI_ACLK = 1'b0;
    logic                    S_AXI_ARESETN = 1'b0;
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR = '0;
    logic                    S_AXI_AWVALID = 1'b0;
    logic                    S_AXI_AWREADY;
    logic [31:0]             S_AXI_WDATA = '0;
    logic [3:0]              S_AXI_WSTRB = '0;
    logic                    S_AXI_WVALID = 1'b0;
    logic                    S_AXI_WREADY;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY = 1'b0;
    logic [1:0]              S_AXI_BRESP;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR = '0;
    logic                    S_AXI_ARVALID = 1'b0;
    logic                    S_AXI_ARREADY;
    logic [31:0]             S_AXI_RDATA;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY = 1'b0;
    logic [1:0]              S_AXI_RRESP;
    logic [32*NUM_REGS-1:0]  ctrl_regs;
    logic [32*NUM_REGS-1:0]  status_in = '0;
    logic [NUM_REGS-1:0]     wr_pulse;

    int                      checks = 0;
    int                      fails = 0;
    int                      pulse_cycles = 0;
    logic [NUM_REGS-1:0]     pulse_seen = '0;
    logic [31:0]             model_regs [NUM_REGS];

    axi4_lite_regbank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .ctrl_regs     (ctrl_regs),
        .status_in     (status_in),
        .wr_pulse      (wr_pulse)
    );

    // Free-running clock.
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    // Count strobe cycles and which registers were strobed.
    always @(negedge S_AXI_ACLK) begin
        if (wr_pulse != '0) begin
            pulse_cycles = pulse_cycles + 1;
            pulse_seen   = pulse_seen | wr_pulse;
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int idx_of(input logic [7:0] addr);
        return int'(addr[7:2]);
    endfunction

    function automatic bit model_write_ok(input logic [7:0] addr);
        int idx;
        idx = idx_of(addr);
        if (idx >= NUM_REGS) return 1'b0;
        return !RO_MASK[idx];
    endfunction

    function automatic logic [NUM_REGS-1:0] model_pulse(input logic [7:0] addr);
        logic [NUM_REGS-1:0] p;
        p = '0;
        if (model_write_ok(addr)) p[idx_of(addr)] = 1'b1;
        return p;
    endfunction

    function automatic logic [32*NUM_REGS-1:0] model_ctrl();
        logic [32*NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!RO_MASK[i]) v[32*i +: 32] = model_regs[i];
        end
        return v;
    endfunction

    function automatic logic [31:0] model_read_data(input logic [7:0] addr);
        int idx;
        idx = idx_of(addr);
        if (idx >= NUM_REGS) return 32'h0;
        if (RO_MASK[idx]) return status_in[32*idx +: 32];
        return model_regs[idx];
    endfunction

    function automatic logic [1:0] model_read_resp(input logic [7:0] addr);
        return (idx_of(addr) >= NUM_REGS) ? SLVERR : OKAY;
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        int idx;
        idx = idx_of(addr);
        if (model_write_ok(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 32'h0;
    endtask

    // One write transaction: AW/W offered after their own delays, B held
    // off for b_hold cycles while its stability is watched.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_delay,
                            input int w_delay, input int b_hold,
                            output logic [1:0] resp, output bit timed_out,
                            output int hold_bad);
        bit aw_pend, w_pend, go_aw, go_w;
        int cyc;
        pulse_cycles = 0;
        pulse_seen   = '0;
        aw_pend      = 1'b1;
        w_pend       = 1'b1;
        timed_out    = 1'b0;
        hold_bad     = 0;
        resp         = 2'bxx;
        cyc          = 0;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        while ((aw_pend || w_pend) && cyc < 200) begin
            S_AXI_AWVALID = aw_pend && (cyc >= aw_delay);
            S_AXI_WVALID  = w_pend && (cyc >= w_delay);
            go_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            go_w  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge S_AXI_ACLK); #1;
            if (go_aw) aw_pend = 1'b0;
            if (go_w) w_pend = 1'b0;
            cyc++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (aw_pend || w_pend) timed_out = 1'b1;
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 50 && !timed_out) begin
            @(posedge S_AXI_ACLK); #1;
            cyc++;
        end
        if (!S_AXI_BVALID) begin
            timed_out = 1'b1;
        end else begin
            resp = S_AXI_BRESP;
            for (int h = 0; h < b_hold; h++) begin
                @(posedge S_AXI_ACLK); #1;
                if (!S_AXI_BVALID || S_AXI_BRESP !== resp || S_AXI_AWREADY || S_AXI_WREADY)
                    hold_bad++;
            end
            S_AXI_BREADY = 1'b1;
            @(posedge S_AXI_ACLK); #1;
            S_AXI_BREADY = 1'b0;
        end
    endtask

    // One read transaction with RREADY held off for r_hold cycles.
    task automatic do_read(input logic [7:0] addr, input int r_hold,
                           output logic [31:0] data, output logic [1:0] resp,
                           output bit timed_out, output int hold_bad);
        bit accepted, go;
        int cyc;
        timed_out     = 1'b0;
        hold_bad      = 0;
        data          = 'x;
        resp          = 2'bxx;
        accepted      = 1'b0;
        cyc           = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!accepted && cyc < 50) begin
            go = S_AXI_ARREADY;
            @(posedge S_AXI_ACLK); #1;
            if (go) accepted = 1'b1;
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        cyc = 0;
        while (accepted && !S_AXI_RVALID && cyc < 50) begin
            @(posedge S_AXI_ACLK); #1;
            cyc++;
        end
        if (!accepted || !S_AXI_RVALID) begin
            timed_out = 1'b1;
        end else begin
            data = S_AXI_RDATA;
            resp = S_AXI_RRESP;
            for (int h = 0; h < r_hold; h++) begin
                @(posedge S_AXI_ACLK); #1;
                if (!S_AXI_RVALID || S_AXI_RDATA !== data || S_AXI_RRESP !== resp || S_AXI_ARREADY)
                    hold_bad++;
            end
            S_AXI_RREADY = 1'b1;
            @(posedge S_AXI_ACLK); #1;
            S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic test_reset();
        model_clear();
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_readies: got %b expected 000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        checks++;
        if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, wr_pulse} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_valids: got %b/%b/%b/%b/%b expected all 0",
                     S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, wr_pulse);
        end
        checks++;
        if (ctrl_regs !== model_ctrl() || S_AXI_RDATA !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_data: ctrl %h rdata %h expected 0", ctrl_regs, S_AXI_RDATA);
        end
        S_AXI_ARESETN = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            fails++;
            $display("[TB] FAIL reset_release_readies: got %b expected 111",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] resp;
        bit to;
        int hb;
        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, to, hb);
        model_write(8'h04, 32'hDEADBEEF, 4'hF);
        checks++;
        if (to !== 1'b0 || resp !== OKAY) begin
            fails++;
            $display("[TB] FAIL same_cycle_bresp: got %b timeout %0b expected %b", resp, to, OKAY);
        end
        checks++;
        if (ctrl_regs[63:32] !== 32'hDEADBEEF) begin
            fails++;
            $display("[TB] FAIL same_cycle_reg1: got %h expected DEADBEEF", ctrl_regs[63:32]);
        end
        checks++;
        if (pulse_cycles !== 1 || pulse_seen !== 8'b0000_0010) begin
            fails++;
            $display("[TB] FAIL same_cycle_pulse: got %0d cycles mask %b expected 1 cycle mask 00000010",
                     pulse_cycles, pulse_seen);
        end
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin
            fails++;
            $display("[TB] FAIL same_cycle_bvalid_drop: got %b expected 0", S_AXI_BVALID);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp;
        bit to;
        int hb;
        do_write(8'h08, 32'h11223344, 4'hF, 0, 0, 0, resp, to, hb);
        model_write(8'h08, 32'h11223344, 4'hF);
        do_write(8'h08, 32'hAABBCCDD, 4'b0101, 3, 0, 0, resp, to, hb);
        model_write(8'h08, 32'hAABBCCDD, 4'b0101);
        checks++;
        if (to !== 1'b0 || resp !== OKAY) begin
            fails++;
            $display("[TB] FAIL w_first_bresp: got %b timeout %0b expected %b", resp, to, OKAY);
        end
        checks++;
        if (ctrl_regs[95:64] !== 32'h11BB33DD) begin
            fails++;
            $display("[TB] FAIL w_first_merge: got %h expected 11BB33DD", ctrl_regs[95:64]);
        end
        do_write(8'h0A, 32'hFFFFFFFF, 4'h0, 0, 2, 0, resp, to, hb);
        checks++;
        if (resp !== OKAY || ctrl_regs !== model_ctrl() || pulse_cycles !== 1 || pulse_seen !== 8'b0000_0100) begin
            fails++;
            $display("[TB] FAIL zero_strb: resp %b reg2 %h pulses %0d mask %b expected 00 %h 1 00000100",
                     resp, ctrl_regs[95:64], pulse_cycles, pulse_seen, model_regs[2]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp;
        logic [31:0] rdata;
        bit to;
        int hb;
        do_write(8'h20, 32'h55AA55AA, 4'hF, 1, 0, 0, resp, to, hb);
        checks++;
        if (to !== 1'b0 || resp !== SLVERR) begin
            fails++;
            $display("[TB] FAIL oor_bresp: got %b timeout %0b expected %b", resp, to, SLVERR);
        end
        checks++;
        if (ctrl_regs !== model_ctrl() || pulse_cycles !== 0) begin
            fails++;
            $display("[TB] FAIL oor_no_change: ctrl %h pulses %0d expected %h 0",
                     ctrl_regs, pulse_cycles, model_ctrl());
        end
        do_read(8'h20, 0, rdata, resp, to, hb);
        checks++;
        if (to !== 1'b0 || rdata !== 32'h0 || resp !== SLVERR) begin
            fails++;
            $display("[TB] FAIL oor_read: got %h/%b timeout %0b expected 00000000/%b", rdata, resp, to, SLVERR);
        end
    endtask

    task automatic test_read_only();
        logic [1:0] resp;
        logic [31:0] rdata;
        bit to;
        int hb;
        status_in[32*5 +: 32] = 32'h12345678;
        do_read(8'h14, 0, rdata, resp, to, hb);
        checks++;
        if (to !== 1'b0 || rdata !== 32'h12345678 || resp !== OKAY) begin
            fails++;
            $display("[TB] FAIL ro_read: got %h/%b timeout %0b expected 12345678/%b", rdata, resp, to, OKAY);
        end
        do_write(8'h14, 32'hCAFEBABE, 4'hF, 0, 1, 0, resp, to, hb);
        checks++;
        if (to !== 1'b0 || resp !== SLVERR || ctrl_regs !== model_ctrl() || pulse_cycles !== 0) begin
            fails++;
            $display("[TB] FAIL ro_write: resp %b pulses %0d ctrl %h expected %b 0 %h",
                     resp, pulse_cycles, ctrl_regs, SLVERR, model_ctrl());
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        logic [31:0] rdata;
        bit to;
        int hb;
        do_write(8'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 10, resp, to, hb);
        model_write(8'h0C, 32'hCAFEF00D, 4'hF);
        checks++;
        if (to !== 1'b0 || resp !== OKAY || hb !== 0) begin
            fails++;
            $display("[TB] FAIL b_hold: resp %b timeout %0b unstable cycles %0d expected %b 0 0",
                     resp, to, hb, OKAY);
        end
        do_read(8'h0C, 10, rdata, resp, to, hb);
        checks++;
        if (to !== 1'b0 || rdata !== model_read_data(8'h0C) || resp !== OKAY || hb !== 0) begin
            fails++;
            $display("[TB] FAIL r_hold: got %h/%b unstable cycles %0d expected %h/%b 0",
                     rdata, resp, hb, model_read_data(8'h0C), OKAY);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        bit to;
        int hb;
        S_AXI_AWADDR  = 8'h00;
        S_AXI_AWVALID = 1'b1;
        repeat (3) @(posedge S_AXI_ACLK);
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL aw_slot_held: AWREADY/WREADY %b expected 01", {S_AXI_AWREADY, S_AXI_WREADY});
        end
        pulse_cycles  = 0;
        S_AXI_ARESETN = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
             S_AXI_BRESP, S_AXI_RRESP, wr_pulse} !== '0 || S_AXI_RDATA !== 32'h0) begin
            fails++;
            $display("[TB] FAIL mid_reset_outputs: ctl %b rdata %h expected 0",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID},
                     S_AXI_RDATA);
        end
        checks++;
        if (ctrl_regs !== model_ctrl()) begin
            fails++;
            $display("[TB] FAIL mid_reset_regs: got %h expected 0", ctrl_regs);
        end
        repeat (2) @(posedge S_AXI_ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARESETN = 1'b1;
        repeat (3) @(posedge S_AXI_ACLK);
        #1;
        checks++;
        if (pulse_cycles !== 0 || S_AXI_BVALID !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset_discard: pulses %0d bvalid %b expected 0 0", pulse_cycles, S_AXI_BVALID);
        end
        do_write(8'h00, 32'h0BADF00D, 4'hF, 0, 0, 0, resp, to, hb);
        model_write(8'h00, 32'h0BADF00D, 4'hF);
        checks++;
        if (to !== 1'b0 || resp !== OKAY || ctrl_regs !== model_ctrl()) begin
            fails++;
            $display("[TB] FAIL post_reset_write: resp %b timeout %0b reg0 %h expected %b 0 0BADF00D",
                     resp, to, ctrl_regs[31:0], OKAY);
        end
    endtask

    task automatic test_random();
        logic [1:0]  resp;
        logic [31:0] rdata, data;
        logic [7:0]  addr;
        logic [3:0]  strb;
        bit to;
        int hb;
        for (int n = 0; n < 60; n++) begin
            addr = 8'(($urandom_range(0, 11) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2), resp, to, hb);
                checks++;
                if (to !== 1'b0 || resp !== (model_write_ok(addr) ? OKAY : SLVERR) || hb !== 0) begin
                    fails++;
                    $display("[TB] FAIL rand_wr_resp[%0d] addr %h: got %b timeout %0b unstable %0d expected %b",
                             n, addr, resp, to, hb, model_write_ok(addr) ? OKAY : SLVERR);
                end
                model_write(addr, data, strb);
                checks++;
                if (ctrl_regs !== model_ctrl() || pulse_seen !== model_pulse(addr) ||
                    pulse_cycles !== (model_write_ok(addr) ? 1 : 0)) begin
                    fails++;
                    $display("[TB] FAIL rand_wr_state[%0d] addr %h: ctrl %h mask %b pulses %0d expected %h %b",
                             n, addr, ctrl_regs, pulse_seen, pulse_cycles, model_ctrl(), model_pulse(addr));
                end
            end else begin
                for (int i = 0; i < NUM_REGS; i++) status_in[32*i +: 32] = $urandom;
                do_read(addr, $urandom_range(0, 2), rdata, resp, to, hb);
                checks++;
                if (to !== 1'b0 || rdata !== model_read_data(addr) || resp !== model_read_resp(addr) || hb !== 0) begin
                    fails++;
                    $display("[TB] FAIL rand_rd[%0d] addr %h: got %h/%b timeout %0b unstable %0d expected %h/%b",
                             n, addr, rdata, resp, to, hb, model_read_data(addr), model_read_resp(addr));
                end
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] start");
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_out_of_range();
        test_read_only();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
